// File: rtl/pattern01_gen.sv
// -----------------------------------------------------------------------------
// pattern01_gen
//
// Serial stimulus source for the "01" pattern-counting path. A WIDTH-bit word
// is accepted through a ready/start handshake and shifted out MSB-first, one
// bit per clock. While shifting, the block counts the 0->1 transitions it
// emits. That count is the reference value for the serial "01" counter this
// block drives.
//
// Parameters
//   WIDTH    bits per word shifted out
//   CW       width of exp_cnt; needs 2**CW > WIDTH/2 (the count never saturates)
//
// Ports
//   clk      in   1      clock, all state changes on the rising edge
//   rst      in   1      synchronous, active-high reset
//   start    in   1      send request, only taken when ready=1
//   data     in   WIDTH  word to send, sampled on the accepting edge only
//   hold     in   1      stall the shift, only honoured while shifting
//   ready    out  1      idle, will accept start
//   x        out  1      serial bit out
//   x_valid  out  1      x carries a newly emitted bit this cycle
//   done     out  1      one-cycle pulse after the last bit of a word
//   exp_cnt  out  CW     0->1 transitions in the current/last word
// -----------------------------------------------------------------------------
module pattern01_gen #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic             hold,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done,
    output logic [CW-1:0]    exp_cnt
);

    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [BW-1:0]    bitcnt_r;
    logic             prev_r;
    logic             ready_r;
    logic             x_r;
    logic             x_valid_r;
    logic             done_r;
    logic [CW-1:0]    exp_cnt_r;

    // Bit leaving the shift register on the next un-held SHIFT edge.
    logic             msb_s;
    assign msb_s = shreg_r[WIDTH-1];

    // Handshake, shifting and transition counting, all in one registered FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            shreg_r   <= {WIDTH{1'b0}};
            bitcnt_r  <= {BW{1'b0}};
            // A leading 1 must not count as a 0->1 transition.
            prev_r    <= 1'b1;
            ready_r   <= 1'b1;
            x_r       <= 1'b0;
            x_valid_r <= 1'b0;
            done_r    <= 1'b0;
            exp_cnt_r <= {CW{1'b0}};
        end else begin
            // done is a single-cycle pulse. Only the DONE state raises it.
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    x_valid_r <= 1'b0;
                    if (start) begin
                        shreg_r   <= data;
                        bitcnt_r  <= BW'(WIDTH);
                        exp_cnt_r <= {CW{1'b0}};
                        prev_r    <= 1'b1;
                        ready_r   <= 1'b0;
                        state_r   <= ST_SHIFT;
                    end else begin
                        ready_r   <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (hold) begin
                        // A stall only drops x_valid. x keeps its last value.
                        x_valid_r <= 1'b0;
                    end else begin
                        x_r       <= msb_s;
                        x_valid_r <= 1'b1;
                        shreg_r   <= {shreg_r[WIDTH-2:0], 1'b0};
                        bitcnt_r  <= bitcnt_r - BW'(1);
                        prev_r    <= msb_s;
                        if (!prev_r && msb_s) begin
                            exp_cnt_r <= exp_cnt_r + CW'(1);
                        end else begin
                            exp_cnt_r <= exp_cnt_r;
                        end
                        if (bitcnt_r == BW'(1)) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end
                end
                ST_DONE: begin
                    x_valid_r <= 1'b0;
                    done_r    <= 1'b1;
                    ready_r   <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    x_valid_r <= 1'b0;
                    ready_r   <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready   = ready_r;
    assign x       = x_r;
    assign x_valid = x_valid_r;
    assign done    = done_r;
    assign exp_cnt = exp_cnt_r;

endmodule

// File: tb/tb_pattern01_gen.sv
// -----------------------------------------------------------------------------
// tb_pattern01_gen
//
// Self-checking bench for pattern01_gen (WIDTH=8, CW=4). Before a word is
// started, the bench pushes the bits that word should emit onto a queue. A
// monitor pops one entry for every x_valid cycle and compares it with x. Each
// test task checks handshake timing, done placement and exp_cnt inline,
// against values the bench works out for itself.
// -----------------------------------------------------------------------------
module tb_pattern01_gen;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] data;
    logic             hold;
    logic             ready;
    logic             x;
    logic             x_valid;
    logic             done;
    logic [CW-1:0]    exp_cnt;

    int   total = 0;
    int   bad   = 0;
    logic exp_q[$];
    logic exp_bit;

    pattern01_gen #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data    (data),
        .hold    (hold),
        .ready   (ready),
        .x       (x),
        .x_valid (x_valid),
        .done    (done),
        .exp_cnt (exp_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every emitted bit must match the next expected bit.
    always @(negedge clk) begin
        if (x_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: x=%0b emitted, expected no bit", x);
            end else begin
                exp_bit = exp_q.pop_front();
                if (x !== exp_bit) begin
                    bad++;
                    $display("FAIL sb_bit: x=%0b expected %0b", x, exp_bit);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Push the first n bits of d, MSB first.
    task automatic push_bits(input logic [WIDTH-1:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[WIDTH-1-i]);
        end
    endtask

    // Reference count of 0->1 transitions, starting from prev=1.
    function automatic int model_cnt(input logic [WIDTH-1:0] d);
        int   c;
        logic p;
        c = 0;
        p = 1'b1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!p && d[i]) c++;
            p = d[i];
        end
        return c;
    endfunction

    // Raise start for one edge (E0). Afterwards data is changed, so that
    // sampling outside the accepting edge would be visible.
    task automatic start_word(input logic [WIDTH-1:0] d);
        start = 1'b1;
        data  = d;
        tick();
        start = 1'b0;
        data  = ~d;
    endtask

    // Count edges until done is seen. n=-1 if the bound runs out.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        total++; if (ready !== 1'b1)   begin bad++; $display("FAIL rst_ready: got %0b want 1", ready); end
        total++; if (x !== 1'b0)       begin bad++; $display("FAIL rst_x: got %0b want 0", x); end
        total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL rst_xvalid: got %0b want 0", x_valid); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL rst_done: got %0b want 0", done); end
        total++; if (exp_cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", exp_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alternating;
        int n;
        push_bits(8'b0101_0101, 8);
        start_word(8'b0101_0101);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL alt_ready_low: got %0b want 0", ready); end
        wait_done(n);
        total++; if (n != 9) begin bad++; $display("FAIL alt_done_edge: got %0d want 9", n); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL alt_ready_back: got %0b want 1", ready); end
        total++; if (int'(exp_cnt) != model_cnt(8'b0101_0101)) begin bad++; $display("FAIL alt_cnt: got %0d want %0d", exp_cnt, model_cnt(8'b0101_0101)); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL alt_bits_left: got %0d want 0", exp_q.size()); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL alt_done_pulse: got %0b want 0", done); end
        total++; if (exp_cnt !== 4'd4) begin bad++; $display("FAIL alt_cnt_hold: got %0d want 4", exp_cnt); end
        total++; if (x !== 1'b1) begin bad++; $display("FAIL alt_x_keep: got %0b want 1", x); end
    endtask

    task automatic test_constant;
        int n;
        // hold is high across the accepting edge, which is in IDLE and must have no effect.
        hold = 1'b1;
        push_bits(8'hFF, 8);
        start_word(8'hFF);
        hold = 1'b0;
        wait_done(n);
        total++; if (n != 9) begin bad++; $display("FAIL ff_done_edge: got %0d want 9", n); end
        total++; if (exp_cnt !== 4'd0) begin bad++; $display("FAIL ff_cnt: got %0d want 0", exp_cnt); end
        tick();
        total++; if (x !== 1'b1) begin bad++; $display("FAIL ff_x_idle: got %0b want 1", x); end
        push_bits(8'h00, 8);
        start_word(8'h00);
        wait_done(n);
        total++; if (n != 9) begin bad++; $display("FAIL zero_done_edge: got %0d want 9", n); end
        total++; if (exp_cnt !== 4'd0) begin bad++; $display("FAIL zero_cnt: got %0d want 0", exp_cnt); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL const_bits_left: got %0d want 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_hold;
        int n;
        push_bits(8'b0110_0110, 8);
        start_word(8'b0110_0110);
        tick();
        tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL hold_xvalid: got %0b want 0", x_valid); end
            total++; if (x !== 1'b1) begin bad++; $display("FAIL hold_x: got %0b want 1", x); end
        end
        hold = 1'b0;
        wait_done(n);
        // Stalled at E5, so done lands on E12.
        total++; if (n != 7) begin bad++; $display("FAIL hold_done_edge: got %0d want 7", n); end
        total++; if (int'(exp_cnt) != model_cnt(8'b0110_0110)) begin bad++; $display("FAIL hold_cnt: got %0d want %0d", exp_cnt, model_cnt(8'b0110_0110)); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL hold_bits_left: got %0d want 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_back_to_back;
        int d1;
        int d2;
        int c1;
        int c2;
        d1 = -1;
        d2 = -1;
        c1 = -1;
        c2 = -1;
        push_bits(8'hA5, 8);
        push_bits(8'hA5, 8);
        start = 1'b1;
        data  = 8'hA5;
        tick();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_low: got %0b want 0", ready); end
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 10) begin
                total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accept: got %0b want 0", ready); end
            end
            if (done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = i;
                    c1 = int'(exp_cnt);
                end else begin
                    d2 = i;
                    c2 = int'(exp_cnt);
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        total++; if (d1 != 9)  begin bad++; $display("FAIL b2b_done1: got %0d want 9", d1); end
        total++; if (d2 != 19) begin bad++; $display("FAIL b2b_done2: got %0d want 19", d2); end
        total++; if (c1 != 3)  begin bad++; $display("FAIL b2b_cnt1: got %0d want 3", c1); end
        total++; if (c2 != 3)  begin bad++; $display("FAIL b2b_cnt2: got %0d want 3", c2); end
        tick();
        tick();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_no_third: got ready=%0b want 1", ready); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_bits_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_mid_reset;
        // Only four bits leave before the reset: 0,1,0,1, which is two transitions.
        push_bits(8'b0101_1111, 4);
        start_word(8'b0101_1111);
        for (int i = 0; i < 4; i++) tick();
        total++; if (exp_cnt !== 4'd2) begin bad++; $display("FAIL mid_cnt_pre: got %0d want 2", exp_cnt); end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (ready !== 1'b1)   begin bad++; $display("FAIL mid_ready: got %0b want 1", ready); end
        total++; if (x !== 1'b0)       begin bad++; $display("FAIL mid_x: got %0b want 0", x); end
        total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL mid_xvalid: got %0b want 0", x_valid); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL mid_done: got %0b want 0", done); end
        total++; if (exp_cnt !== 4'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", exp_cnt); end
        tick();
    endtask

    task automatic test_abort_restart;
        int n;
        push_bits(8'hF0, 4);
        start_word(8'hF0);
        for (int i = 0; i < 4; i++) tick();
        total++; if (x_valid !== 1'b1) begin bad++; $display("FAIL abort_xvalid_pre: got %0b want 1", x_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL abort_xvalid: got %0b want 0", x_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_no_done: got %0b want 0", done); end
        end
        push_bits(8'h0F, 8);
        start_word(8'h0F);
        wait_done(n);
        total++; if (n != 9) begin bad++; $display("FAIL restart_done_edge: got %0d want 9", n); end
        total++; if (int'(exp_cnt) != model_cnt(8'h0F)) begin bad++; $display("FAIL restart_cnt: got %0d want %0d", exp_cnt, model_cnt(8'h0F)); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL restart_bits_left: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        data  = 8'h00;
        test_reset();
        test_alternating();
        test_constant();
        test_hold();
        test_back_to_back();
        test_mid_reset();
        test_abort_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
